// File: rtl/store_unit_pkg.sv
// Shared types and constants for the memory unit (load unit, store buffer,
// memory arbiter).
package store_unit_pkg;

    // Machine word width used on every data/address path.
    localparam int unsigned WORD_W = 32;

    // Access width of a store (loads always travel as a full word).
    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'd0,
        WIDTH_HALF = 2'd1,
        WIDTH_WORD = 2'd2
    } store_width_t;

    // Bus width driven for every load transaction.
    localparam store_width_t WORD = WIDTH_WORD;

    // Memory arbiter transaction sequencer.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_BUSY  = 2'd1,
        STORE_BUSY = 2'd2
    } arbiter_fsm_t;

endpackage

// File: rtl/memory_arbiter.sv
// Memory arbiter: shares the single external memory bus between the load unit
// and the store buffer drain port, one transaction in flight at a time.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   flush_i                    pipeline flush (drops pending/in-flight loads)
//   ldu_request_i/address_i    load request, held until ldu_grant_o
//   ldu_grant_o                load accepted (pulse in arbitration cycle)
//   ldu_data_o/ldu_valid_o     returned load data and its one-cycle valid
//   stb_request_i/full_i       store buffer has an entry / is full
//   stb_address/data/width_i   head entry of the store buffer
//   stb_grant_o                store accepted; store buffer pops its head
//   stb_done_o                 store completed on the bus
//   bus_*_o                    registered bus transaction, held to bus_done_i
//   bus_data_i, bus_done_i     read data and single-cycle completion
module memory_arbiter
    import store_unit_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                ldu_request_i,
    input  logic [WORD_W-1:0]   ldu_address_i,
    output logic                ldu_grant_o,
    output logic [WORD_W-1:0]   ldu_data_o,
    output logic                ldu_valid_o,
    input  logic                stb_request_i,
    input  logic                stb_full_i,
    input  logic [WORD_W-1:0]   stb_address_i,
    input  logic [WORD_W-1:0]   stb_data_i,
    input  store_width_t        stb_width_i,
    output logic                stb_grant_o,
    output logic                stb_done_o,
    output logic                bus_request_o,
    output logic                bus_write_o,
    output logic [WORD_W-1:0]   bus_address_o,
    output logic [WORD_W-1:0]   bus_data_o,
    output store_width_t        bus_width_o,
    input  logic [WORD_W-1:0]   bus_data_i,
    input  logic                bus_done_i
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    arbiter_fsm_t     state;
    logic [CNT_W-1:0] starve_cnt;
    logic             skip_load;
    logic             store_win_c;
    logic             load_win_c;
    logic             starved_c;

    // Arbitration: the grants must pulse in the same cycle as the request,
    // so they are decoded combinationally and only while IDLE.
    always_comb begin
        store_win_c = 1'b0;
        load_win_c  = 1'b0;
        starved_c   = (starve_cnt == CNT_W'(STARVE_LIMIT));
        if (!rst_i && state == IDLE) begin
            if (stb_request_i && (stb_full_i || starved_c || !ldu_request_i)) begin
                store_win_c = 1'b1;
            end else if (ldu_request_i && !flush_i) begin
                load_win_c = 1'b1;
            end
        end
    end

    assign ldu_grant_o = load_win_c;
    assign stb_grant_o = store_win_c;

    // Transaction sequencer, starvation counter and registered bus outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            skip_load     <= 1'b0;
            ldu_data_o    <= '0;
            ldu_valid_o   <= 1'b0;
            stb_done_o    <= 1'b0;
            bus_request_o <= 1'b0;
            bus_write_o   <= 1'b0;
            bus_address_o <= '0;
            bus_data_o    <= '0;
            bus_width_o   <= WIDTH_BYTE;
        end else begin
            ldu_valid_o <= 1'b0;
            stb_done_o  <= 1'b0;
            unique case (state)
                IDLE: begin
                    skip_load <= 1'b0;
                    if (store_win_c) begin
                        state         <= STORE_BUSY;
                        starve_cnt    <= '0;
                        bus_request_o <= 1'b1;
                        bus_write_o   <= 1'b1;
                        bus_address_o <= stb_address_i;
                        bus_data_o    <= stb_data_i;
                        bus_width_o   <= stb_width_i;
                    end else if (load_win_c) begin
                        state         <= LOAD_BUSY;
                        bus_request_o <= 1'b1;
                        bus_write_o   <= 1'b0;
                        bus_address_o <= ldu_address_i;
                        bus_data_o    <= '0;
                        bus_width_o   <= WORD;
                        if (stb_request_i && !starved_c) begin
                            starve_cnt <= starve_cnt + CNT_W'(1);
                        end
                    end
                end
                LOAD_BUSY: begin
                    // The bus cannot be aborted; a flush only hides the result.
                    if (flush_i) begin
                        skip_load <= 1'b1;
                    end
                    if (bus_done_i) begin
                        state         <= IDLE;
                        bus_request_o <= 1'b0;
                        ldu_data_o    <= bus_data_i;
                        ldu_valid_o   <= !(skip_load || flush_i);
                        skip_load     <= 1'b0;
                    end
                end
                STORE_BUSY: begin
                    if (bus_done_i) begin
                        state         <= IDLE;
                        bus_request_o <= 1'b0;
                        stb_done_o    <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: scenario tasks drive the ports
// cycle by cycle; returned load data and completed stores are scoreboarded.
module tb_memory_arbiter;
    import store_unit_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         flush_i;
    logic         ldu_request_i;
    logic [31:0]  ldu_address_i;
    logic         ldu_grant_o;
    logic [31:0]  ldu_data_o;
    logic         ldu_valid_o;
    logic         stb_request_i;
    logic         stb_full_i;
    logic [31:0]  stb_address_i;
    logic [31:0]  stb_data_i;
    store_width_t stb_width_i;
    logic         stb_grant_o;
    logic         stb_done_o;
    logic         bus_request_o;
    logic         bus_write_o;
    logic [31:0]  bus_address_o;
    logic [31:0]  bus_data_o;
    store_width_t bus_width_o;
    logic [31:0]  bus_data_i;
    logic         bus_done_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_load_q[$];
    logic [31:0] exp_store_q[$];
    logic [31:0] mon_exp;

    always #5 clk_i = ~clk_i;

    memory_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .ldu_request_i (ldu_request_i),
        .ldu_address_i (ldu_address_i),
        .ldu_grant_o   (ldu_grant_o),
        .ldu_data_o    (ldu_data_o),
        .ldu_valid_o   (ldu_valid_o),
        .stb_request_i (stb_request_i),
        .stb_full_i    (stb_full_i),
        .stb_address_i (stb_address_i),
        .stb_data_i    (stb_data_i),
        .stb_width_i   (stb_width_i),
        .stb_grant_o   (stb_grant_o),
        .stb_done_o    (stb_done_o),
        .bus_request_o (bus_request_o),
        .bus_write_o   (bus_write_o),
        .bus_address_o (bus_address_o),
        .bus_data_o    (bus_data_o),
        .bus_width_o   (bus_width_o),
        .bus_data_i    (bus_data_i),
        .bus_done_i    (bus_done_i)
    );

    // Scoreboard side: every valid/done pulse must match a queued expectation.
    always @(negedge clk_i) begin
        if (ldu_valid_o === 1'b1) begin
            checks++;
            if (exp_load_q.size() == 0) begin
                errors++;
                $display("FAIL sb_load_unexpected: got data %h, none expected", ldu_data_o);
            end else begin
                mon_exp = exp_load_q.pop_front();
                if (ldu_data_o !== mon_exp) begin
                    errors++;
                    $display("FAIL sb_load_data: got %h, expected %h", ldu_data_o, mon_exp);
                end
            end
        end
        if (stb_done_o === 1'b1) begin
            checks++;
            if (exp_store_q.size() == 0) begin
                errors++;
                $display("FAIL sb_store_unexpected: done for address %h, none expected", bus_address_o);
            end else begin
                mon_exp = exp_store_q.pop_front();
                if (bus_address_o !== mon_exp) begin
                    errors++;
                    $display("FAIL sb_store_addr: got %h, expected %h", bus_address_o, mon_exp);
                end
            end
        end
        if (stb_grant_o === 1'b1) begin
            checks++;
            if (stb_request_i !== 1'b1) begin
                errors++;
                $display("FAIL grant_without_request: stb_grant_o=1 with stb_request_i=%b", stb_request_i);
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        flush_i       = 1'b0;
        ldu_request_i = 1'b0;
        ldu_address_i = '0;
        stb_request_i = 1'b0;
        stb_full_i    = 1'b0;
        stb_address_i = '0;
        stb_data_i    = '0;
        stb_width_i   = WIDTH_BYTE;
        bus_data_i    = '0;
        bus_done_i    = 1'b0;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        ldu_request_i = 1'b1;
        stb_request_i = 1'b1;
        sample();
        checks++;
        if (ldu_grant_o !== 1'b0 || stb_grant_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_grants: ldu=%b stb=%b, expected 0 0", ldu_grant_o, stb_grant_o);
        end
        cyc();
        cyc();
        sample();
        checks++;
        if ({bus_request_o, bus_write_o, ldu_valid_o, stb_done_o} !== 4'b0000 ||
            ldu_data_o !== 32'h0 || bus_address_o !== 32'h0 || bus_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b wr=%b val=%b done=%b data=%h addr=%h, expected all 0",
                     bus_request_o, bus_write_o, ldu_valid_o, stb_done_o, ldu_data_o, bus_address_o);
        end
        idle_inputs();
        rst_i = 1'b0;
        cyc();
    endtask

    task automatic test_load_only();
        ldu_request_i = 1'b1;
        ldu_address_i = 32'h0000_1000;
        sample();
        checks++;
        if (ldu_grant_o !== 1'b1 || stb_grant_o !== 1'b0) begin
            errors++;
            $display("FAIL load_grant: ldu=%b stb=%b, expected 1 0", ldu_grant_o, stb_grant_o);
        end
        cyc();
        ldu_request_i = 1'b0;
        sample();
        checks++;
        if (bus_request_o !== 1'b1 || bus_write_o !== 1'b0 ||
            bus_address_o !== 32'h0000_1000 || bus_width_o !== WIDTH_WORD) begin
            errors++;
            $display("FAIL load_bus: req=%b wr=%b addr=%h width=%0d, expected 1 0 00001000 2",
                     bus_request_o, bus_write_o, bus_address_o, bus_width_o);
        end
        cyc();
        cyc();
        bus_done_i = 1'b1;
        bus_data_i = 32'hDEAD_BEEF;
        exp_load_q.push_back(32'hDEAD_BEEF);
        sample();
        checks++;
        if (ldu_valid_o !== 1'b0 || bus_request_o !== 1'b1) begin
            errors++;
            $display("FAIL load_hold: valid=%b req=%b, expected 0 1", ldu_valid_o, bus_request_o);
        end
        cyc();
        bus_done_i = 1'b0;
        sample();
        checks++;
        if (ldu_valid_o !== 1'b1 || ldu_data_o !== 32'hDEAD_BEEF || bus_request_o !== 1'b0) begin
            errors++;
            $display("FAIL load_result: valid=%b data=%h req=%b, expected 1 deadbeef 0",
                     ldu_valid_o, ldu_data_o, bus_request_o);
        end
        cyc();
    endtask

    task automatic test_store_only();
        stb_request_i = 1'b1;
        stb_address_i = 32'h0000_2000;
        stb_data_i    = 32'h1234_5678;
        stb_width_i   = WIDTH_BYTE;
        sample();
        checks++;
        if (stb_grant_o !== 1'b1 || ldu_grant_o !== 1'b0) begin
            errors++;
            $display("FAIL store_grant: stb=%b ldu=%b, expected 1 0", stb_grant_o, ldu_grant_o);
        end
        cyc();
        stb_request_i = 1'b0;
        sample();
        checks++;
        if (bus_request_o !== 1'b1 || bus_write_o !== 1'b1 || bus_address_o !== 32'h2000 ||
            bus_data_o !== 32'h1234_5678 || bus_width_o !== WIDTH_BYTE) begin
            errors++;
            $display("FAIL store_bus: req=%b wr=%b addr=%h data=%h width=%0d, expected 1 1 2000 12345678 0",
                     bus_request_o, bus_write_o, bus_address_o, bus_data_o, bus_width_o);
        end
        cyc();
        bus_done_i = 1'b1;
        exp_store_q.push_back(32'h0000_2000);
        sample();
        checks++;
        if (stb_done_o !== 1'b0) begin
            errors++;
            $display("FAIL store_done_early: done=%b, expected 0", stb_done_o);
        end
        cyc();
        bus_done_i = 1'b0;
        sample();
        checks++;
        if (stb_done_o !== 1'b1 || bus_request_o !== 1'b0) begin
            errors++;
            $display("FAIL store_done: done=%b req=%b, expected 1 0", stb_done_o, bus_request_o);
        end
        cyc();
    endtask

    task automatic test_starvation();
        string exp_order = "LLLLSL";
        byte   got;
        apply_reset();
        ldu_request_i = 1'b1;
        stb_request_i = 1'b1;
        stb_full_i    = 1'b0;
        stb_address_i = 32'h0000_4000;
        stb_data_i    = 32'h5555_AAAA;
        stb_width_i   = WIDTH_WORD;
        for (int i = 0; i < 6; i++) begin
            ldu_address_i = 32'h0000_3000 + 32'(i * 4);
            sample();
            got = stb_grant_o ? "S" : (ldu_grant_o ? "L" : "-");
            checks++;
            if (got != exp_order[i]) begin
                errors++;
                $display("FAIL starve_order[%0d]: got %c, expected %c", i, got, exp_order[i]);
            end
            cyc();
            bus_done_i = 1'b1;
            bus_data_i = 32'hA000_0000 + 32'(i);
            if (exp_order[i] == "S") exp_store_q.push_back(32'h0000_4000);
            else exp_load_q.push_back(32'hA000_0000 + 32'(i));
            sample();
            checks++;
            if (bus_request_o !== 1'b1 || bus_write_o !== (exp_order[i] == "S")) begin
                errors++;
                $display("FAIL starve_bus[%0d]: req=%b wr=%b, expected 1 %b",
                         i, bus_request_o, bus_write_o, exp_order[i] == "S");
            end
            cyc();
            bus_done_i = 1'b0;
        end
        idle_inputs();
        cyc();
        cyc();
    endtask

    task automatic test_full_buffer();
        apply_reset();
        ldu_request_i = 1'b1;
        ldu_address_i = 32'h0000_5000;
        stb_request_i = 1'b1;
        stb_full_i    = 1'b1;
        stb_address_i = 32'h0000_6000;
        sample();
        checks++;
        if (stb_grant_o !== 1'b1 || ldu_grant_o !== 1'b0) begin
            errors++;
            $display("FAIL full_store_first: stb=%b ldu=%b, expected 1 0", stb_grant_o, ldu_grant_o);
        end
        cyc();
        stb_request_i = 1'b0;
        stb_full_i    = 1'b0;
        bus_done_i    = 1'b1;
        exp_store_q.push_back(32'h0000_6000);
        cyc();
        bus_done_i = 1'b0;
        sample();
        checks++;
        if (ldu_grant_o !== 1'b1) begin
            errors++;
            $display("FAIL full_load_next: ldu=%b, expected 1", ldu_grant_o);
        end
        cyc();
        ldu_request_i = 1'b0;
        bus_done_i    = 1'b1;
        bus_data_i    = 32'h0BAD_F00D;
        exp_load_q.push_back(32'h0BAD_F00D);
        cyc();
        idle_inputs();
        cyc();
    endtask

    task automatic test_flush_load();
        // Flush in the middle of the load, done arrives a cycle later.
        ldu_request_i = 1'b1;
        ldu_address_i = 32'h0000_7000;
        cyc();
        ldu_request_i = 1'b0;
        cyc();
        flush_i = 1'b1;
        sample();
        checks++;
        if (bus_request_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_no_abort: req=%b, expected 1", bus_request_o);
        end
        cyc();
        flush_i    = 1'b0;
        bus_done_i = 1'b1;
        bus_data_i = 32'hBAD0_0001;
        cyc();
        bus_done_i    = 1'b0;
        ldu_request_i = 1'b1;
        ldu_address_i = 32'h0000_7100;
        sample();
        checks++;
        if (ldu_valid_o !== 1'b0 || bus_request_o !== 1'b0 || ldu_grant_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_suppress: valid=%b req=%b grant=%b, expected 0 0 1",
                     ldu_valid_o, bus_request_o, ldu_grant_o);
        end
        cyc();
        ldu_request_i = 1'b0;
        bus_done_i    = 1'b1;
        bus_data_i    = 32'h600D_0001;
        exp_load_q.push_back(32'h600D_0001);
        cyc();
        bus_done_i = 1'b0;
        sample();
        checks++;
        if (ldu_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_cleared: valid=%b, expected 1", ldu_valid_o);
        end
        cyc();
        // Flush in the very cycle the bus completes.
        ldu_request_i = 1'b1;
        ldu_address_i = 32'h0000_7200;
        cyc();
        ldu_request_i = 1'b0;
        flush_i       = 1'b1;
        bus_done_i    = 1'b1;
        bus_data_i    = 32'hBAD0_0002;
        cyc();
        flush_i    = 1'b0;
        bus_done_i = 1'b0;
        sample();
        checks++;
        if (ldu_valid_o !== 1'b0 || bus_request_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_same_cycle: valid=%b req=%b, expected 0 0", ldu_valid_o, bus_request_o);
        end
        cyc();
    endtask

    task automatic test_flush_idle();
        ldu_request_i = 1'b1;
        ldu_address_i = 32'h0000_8000;
        flush_i       = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample();
            checks++;
            if (ldu_grant_o !== 1'b0 || stb_grant_o !== 1'b0) begin
                errors++;
                $display("FAIL flush_idle_nogrant[%0d]: ldu=%b stb=%b, expected 0 0", i, ldu_grant_o, stb_grant_o);
            end
            cyc();
        end
        sample();
        checks++;
        if (bus_request_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_bus: req=%b, expected 0", bus_request_o);
        end
        // A store is committed: flush must not block or cancel it.
        ldu_request_i = 1'b0;
        stb_request_i = 1'b1;
        stb_address_i = 32'h0000_8800;
        cyc();
        stb_request_i = 1'b0;
        sample();
        checks++;
        if (bus_request_o !== 1'b1 || bus_write_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_store: req=%b wr=%b, expected 1 1", bus_request_o, bus_write_o);
        end
        bus_done_i = 1'b1;
        exp_store_q.push_back(32'h0000_8800);
        cyc();
        bus_done_i = 1'b0;
        sample();
        checks++;
        if (stb_done_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_store_done: done=%b, expected 1", stb_done_o);
        end
        flush_i = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_store();
        stb_request_i = 1'b1;
        stb_address_i = 32'h0000_9000;
        stb_data_i    = 32'hCAFE_0000;
        stb_width_i   = WIDTH_HALF;
        cyc();
        stb_request_i = 1'b0;
        sample();
        checks++;
        if (bus_request_o !== 1'b1 || bus_width_o !== WIDTH_HALF) begin
            errors++;
            $display("FAIL rst_store_bus: req=%b width=%0d, expected 1 1", bus_request_o, bus_width_o);
        end
        cyc();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        sample();
        checks++;
        if ({bus_request_o, bus_write_o, stb_done_o, ldu_valid_o} !== 4'b0000 || bus_address_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_store: req=%b wr=%b done=%b valid=%b addr=%h, expected all 0",
                     bus_request_o, bus_write_o, stb_done_o, ldu_valid_o, bus_address_o);
        end
        bus_done_i = 1'b1;
        cyc();
        bus_done_i = 1'b0;
        sample();
        checks++;
        if (stb_done_o !== 1'b0 || ldu_valid_o !== 1'b0 || bus_request_o !== 1'b0) begin
            errors++;
            $display("FAIL stray_done: done=%b valid=%b req=%b, expected 0 0 0",
                     stb_done_o, ldu_valid_o, bus_request_o);
        end
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        test_reset();
        test_load_only();
        test_store_only();
        test_starvation();
        test_full_buffer();
        test_flush_load();
        test_flush_idle();
        test_reset_mid_store();
        sample();
        checks++;
        if (exp_load_q.size() != 0 || exp_store_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d loads and %0d stores outstanding, expected 0 0",
                     exp_load_q.size(), exp_store_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single external memory bus between the load unit and the store buffer drain port.
- Sits between the memory unit (load unit and store unit / store buffer) and the bus controller.
- Loads win by default to cut load latency. The store buffer wins when it is full, or when loads have starved it for STARVE_LIMIT consecutive grants.
- Only one transaction is in flight at a time. Every transaction is sequenced by a 3-state FSM.

Parameters:
- STARVE_LIMIT, 4, consecutive load grants allowed while a store is pending before a store is forced.

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  pipeline flush
- ldu_request_i  in  1  load request, held until ldu_grant_o
- ldu_address_i  in  32  load address
- ldu_grant_o  out  1  one-cycle pulse: load accepted
- ldu_data_o  out  32  loaded data
- ldu_valid_o  out  1  one-cycle pulse: ldu_data_o valid
- stb_request_i  in  1  store buffer has a committed entry to drain
- stb_full_i  in  1  store buffer full
- stb_address_i  in  32  store address
- stb_data_i  in  32  store data
- stb_width_i  in  2  store_width_t (byte/half/word)
- stb_grant_o  out  1  one-cycle pulse: store accepted; store buffer pops head
- stb_done_o  out  1  one-cycle pulse: store completed on bus
- bus_request_o  out  1  transaction valid, held until bus_done_i
- bus_write_o  out  1  1 = store, 0 = load
- bus_address_o  out  32  transaction address
- bus_data_o  out  32  write data
- bus_width_o  out  2  store_width_t (word for loads)
- bus_data_i  in  32  read data
- bus_done_i  in  1  transaction complete, single-cycle pulse

Behaviour:
- Reset (rst_i = 1 at a clock edge):
  - state to IDLE, starve counter to 0, skip_load flag to 0.
  - All outputs 0.
  - rst_i overrides every other input.
- FSM states:
  - IDLE: no transaction in flight; arbitrate.
  - LOAD_BUSY: load on bus.
  - STORE_BUSY: store on bus.
- Arbitration in IDLE (combinational on the inputs):
  - Store wins if stb_request_i & (stb_full_i | starve_cnt == STARVE_LIMIT | !ldu_request_i).
  - Otherwise load wins if ldu_request_i & !flush_i.
  - A load request is ignored in any cycle with flush_i = 1.
- Grant timing:
  - The winner's grant pulses in the arbitration cycle.
  - bus_* outputs are registered and driven from the next cycle; the FSM moves to the matching BUSY state.
  - bus_request_o stays high with stable address, data and width until the bus_done_i cycle, then drops next cycle.
- Completion:
  - On bus_done_i in LOAD_BUSY: ldu_data_o <= bus_data_i, ldu_valid_o pulses next cycle, return to IDLE.
  - On bus_done_i in STORE_BUSY: stb_done_o pulses next cycle, return to IDLE.
  - Minimum turnaround is one IDLE cycle between transactions. Minimum load latency is grant + 1 + bus latency + 1.
- Starve counter:
  - Increments on a load grant while stb_request_i = 1.
  - Saturates at STARVE_LIMIT.
  - Clears on a store grant.
- Flush:
  - Flush during LOAD_BUSY cannot abort the bus. The transaction completes, but ldu_valid_o is suppressed.
  - A skip_load flag records the pending suppression. It is set by flush in LOAD_BUSY and cleared on return to IDLE.
  - Flush never affects IDLE store grants or STORE_BUSY, because stores are committed.
- Boundary cases:
  - bus_done_i in IDLE is ignored.
  - bus_done_i in the same cycle as flush_i in LOAD_BUSY: the result is dropped.
  - Simultaneous requests with stb_full_i = 1: the store wins.
  - The load request and store request may change only after their grant. No store is ever granted while stb_request_i = 0.

Decomposition:
- Add to the existing store_unit_pkg:
  - arbiter_fsm_t enum {IDLE, LOAD_BUSY, STORE_BUSY}.
  - WORD width constant (store_width_t already exists there).
- No sub-module; a single FSM plus counter is sufficient.

Test Plan:
- Load only: ldu_request_i = 1, address 0x0000_1000. Expect:
  - ldu_grant_o in cycle 0; bus_request_o = 1 and bus_write_o = 0 from cycle 1.
  - bus_done_i in cycle 3 with data 0xDEAD_BEEF, then ldu_valid_o = 1 and ldu_data_o = 0xDEAD_BEEF in cycle 4.
- Store only: stb_request_i = 1, address 0x2000, data 0x1234_5678, width byte. Expect:
  - stb_grant_o in cycle 0; bus_write_o = 1 with bus_width_o = byte.
  - stb_done_o pulses the cycle after bus_done_i.
- Starvation: both requests held continuously with STARVE_LIMIT = 4 and stb_full_i = 0. Expect grant order L, L, L, L, S, L… with the counter cleared after S.
- Full buffer: both requests asserted with stb_full_i = 1. Expect the store granted first even with starve_cnt = 0.
- Flush during a load:
  - flush_i = 1 in cycle 2 of LOAD_BUSY: after bus_done_i, ldu_valid_o stays 0 and the FSM is in IDLE one cycle later.
  - flush_i = 1 with ldu_request_i in IDLE: no grant.
- Reset mid-store: rst_i = 1 during STORE_BUSY. Expect:
  - Next cycle bus_request_o = 0, all pulses 0, state IDLE, starve counter 0.
  - A stray bus_done_i afterwards is ignored.
